// File: rtl/pcileech_pkg.sv
// Shared constants and types for the PCILeech FT601 RX command router:
// control-word magic, command type codes, FSM state encoding and wait timeout.
package pcileech_pkg;

    localparam logic [7:0] MAGIC       = 8'h77;
    localparam logic [7:0] TYPE_TLP    = 8'h00;
    localparam logic [7:0] TYPE_CFG    = 8'h01;
    localparam logic [7:0] TYPE_LB     = 8'h02;
    localparam logic [9:0] TIMEOUT_MAX = 10'd1023;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD0      = 3'd1,
        S_W0       = 3'd2,
        S_RD1      = 3'd3,
        S_W1       = 3'd4,
        S_DISPATCH = 3'd5
    } rx_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pcileech_rx_timeout.sv
// 10-bit wait counter for the router: counts while inc is high, holds at
// TIMEOUT_MAX and flags expiry; clr returns it to zero.
module pcileech_rx_timeout
    import pcileech_pkg::*;
(
    input  logic FT601_CLK,
    input  logic FT601_RESET,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    logic [9:0] cnt_r;

    // Wait counter, saturating at the timeout value.
    always_ff @(posedge FT601_CLK) begin
        if (FT601_RESET) begin
            cnt_r <= 10'd0;
        end else if (clr) begin
            cnt_r <= 10'd0;
        end else if (inc && (cnt_r != TIMEOUT_MAX)) begin
            cnt_r <= cnt_r + 10'd1;
        end
    end

    assign expired = (cnt_r == TIMEOUT_MAX);

endmodule

// File: rtl/pcileech_rx_router.sv
// Splits the FT601 RX word stream into two-word commands and routes them to
// the TLP stream, config writes or (with PCILEECH_RX_LOOPBACK_EN) the loopback stream.
module pcileech_rx_router
    import pcileech_pkg::*;
(
    input  logic        FT601_CLK,
    input  logic        FT601_RESET,
    input  logic [31:0] fifo_rx_dout,
    input  logic        fifo_rx_empty,
    output logic        fifo_rx_rd,
    output logic [31:0] tlp_data,
    output logic        tlp_last,
    output logic        tlp_valid,
    input  logic        tlp_ready,
    output logic [7:0]  cfg_addr,
    output logic [31:0] cfg_data,
    output logic        cfg_wr,
    output logic [63:0] lb_data,
    output logic        lb_valid,
    input  logic        lb_ready,
    output logic [15:0] err_cnt
);

    rx_state_e   state_r;
    logic [31:0] w0_r;
    logic [31:0] w1_r;
    logic [31:0] tlp_data_r;
    logic        tlp_last_r;
    logic        tlp_valid_r;
    logic [7:0]  cfg_addr_r;
    logic [31:0] cfg_data_r;
    logic        cfg_wr_r;
    logic [15:0] err_r;
    logic        tmo_clr_s;
    logic        tmo_inc_s;
    logic        tmo_expired_s;
    logic        unused_s;

    // The FIFO pops on the edge that sees the strobe, so the word is on
    // fifo_rx_dout during the following RD state.
    assign fifo_rx_rd = ~FT601_RESET & ~fifo_rx_empty &
                        ((state_r == S_IDLE) | (state_r == S_W0));

    assign tmo_clr_s = (state_r != S_W0);
    assign tmo_inc_s = (state_r == S_W0) & fifo_rx_empty & ~tmo_expired_s;

    pcileech_rx_timeout u_timeout (
        .FT601_CLK   (FT601_CLK),
        .FT601_RESET (FT601_RESET),
        .clr         (tmo_clr_s),
        .inc         (tmo_inc_s),
        .expired     (tmo_expired_s)
    );

`ifdef PCILEECH_RX_LOOPBACK_EN
    logic [63:0] lb_data_r;
    logic        lb_valid_r;
    assign lb_data  = lb_data_r;
    assign lb_valid = lb_valid_r;
`else
    assign lb_data  = 64'd0;
    assign lb_valid = 1'b0;
`endif

    // Command assembly, validation and dispatch.
    always_ff @(posedge FT601_CLK) begin
        if (FT601_RESET) begin
            state_r     <= S_IDLE;
            w0_r        <= 32'd0;
            w1_r        <= 32'd0;
            tlp_data_r  <= 32'd0;
            tlp_last_r  <= 1'b0;
            tlp_valid_r <= 1'b0;
            cfg_addr_r  <= 8'd0;
            cfg_data_r  <= 32'd0;
            cfg_wr_r    <= 1'b0;
            err_r       <= 16'd0;
`ifdef PCILEECH_RX_LOOPBACK_EN
            lb_data_r   <= 64'd0;
            lb_valid_r  <= 1'b0;
`endif
        end else begin
            cfg_wr_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (~fifo_rx_empty) begin
                        state_r <= S_RD0;
                    end
                end
                S_RD0: begin
                    w0_r    <= fifo_rx_dout;
                    state_r <= S_W0;
                end
                S_W0: begin
                    if (~fifo_rx_empty) begin
                        state_r <= S_RD1;
                    end else if (tmo_expired_s) begin
                        err_r   <= sat_inc16(err_r);
                        state_r <= S_IDLE;
                    end
                end
                S_RD1: begin
                    w1_r    <= fifo_rx_dout;
                    state_r <= S_W1;
                end
                S_W1: begin
                    if (w1_r[31:24] != MAGIC) begin
                        // Slip by one word: the bad control word may be the next payload.
                        w0_r    <= w1_r;
                        err_r   <= sat_inc16(err_r);
                        state_r <= S_W0;
                    end else begin
                        state_r <= S_DISPATCH;
                        case (w1_r[23:16])
                            TYPE_TLP: begin
                                tlp_data_r  <= w0_r;
                                tlp_last_r  <= w1_r[0];
                                tlp_valid_r <= 1'b1;
                            end
                            TYPE_CFG: begin
                                cfg_addr_r <= w1_r[15:8];
                                cfg_data_r <= w0_r;
                                cfg_wr_r   <= 1'b1;
                            end
`ifdef PCILEECH_RX_LOOPBACK_EN
                            TYPE_LB: begin
                                lb_data_r  <= {w1_r, w0_r};
                                lb_valid_r <= 1'b1;
                            end
`endif
                            default: begin
                            end
                        endcase
                    end
                end
                S_DISPATCH: begin
                    if (tlp_valid_r) begin
                        if (tlp_ready) begin
                            tlp_valid_r <= 1'b0;
                            state_r     <= S_IDLE;
                        end
                    end
`ifdef PCILEECH_RX_LOOPBACK_EN
                    else if (lb_valid_r) begin
                        if (lb_ready) begin
                            lb_valid_r <= 1'b0;
                            state_r    <= S_IDLE;
                        end
                    end
`endif
                    else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign tlp_data  = tlp_data_r;
    assign tlp_last  = tlp_last_r;
    assign tlp_valid = tlp_valid_r;
    assign cfg_addr  = cfg_addr_r;
    assign cfg_data  = cfg_data_r;
    assign cfg_wr    = cfg_wr_r;
    assign err_cnt   = err_r;

    assign unused_s = ^{lb_ready, w1_r[7:1]};

endmodule
